matmult_run_ctrl: RTL and testbench
===================================

Name: matmult_run_ctrl

Overview:
Control and address-generation stage that drives the MatMult datapath's operand read ports (a, b), its result write port (c), and its MAC accumulator controls.
It runs one full NxN matrix multiply per start command, C[i][j] = sum over k of A[i][k]*B[k][j], with matrices stored row-major in sync 1R1W RAMs.
It also owns the channel request/release handshake for all three RAMs and reports busy/done to the system.

Parameters:
N, 10, matrix dimension; element count N*N must fit in AW bits
AW, 7, RAM address width
RD_LAT, 1, sync RAM read latency in cycles (q valid RD_LAT cycles after re)

Ports:
clk  in  1  clock
arst_n  in  1  reset, asynchronous, active-low
start  in  1  start one matrix multiply; sampled only in IDLE
busy  out  1  high from WAIT_REQ through RELEASE
done  out  1  one-cycle pulse in RELEASE
a_req_vz  in  1  a-channel buffer available (level)
b_req_vz  in  1  b-channel buffer available (level)
c_req_vz  in  1  c-channel buffer available (level)
a_rls_lz  out  1  a-channel release pulse
b_rls_lz  out  1  b-channel release pulse
c_rls_lz  out  1  c-channel release pulse
a_re  out  1  A read enable
a_radr  out  AW  A read address, i*N+k
b_re  out  1  B read enable
b_radr  out  AW  B read address, k*N+j
c_we  out  1  C write enable
c_wadr  out  AW  C write address, i*N+j
acc_en  out  1  datapath accumulator update (product valid this cycle)
acc_clr  out  1  with acc_en: acc <= product instead of acc + product

Behaviour:
- All outputs are decoded from registered state/counters only. There is no combinational path from any input to any output.
- Reset (asynchronous, any time including mid-run): state IDLE, counters i/j/k = 0, all outputs 0.
- A reset mid-run abandons the run: no write, no release pulse, no done.
- FSM states: IDLE, WAIT_REQ, MAC, DRAIN, WRITE, RELEASE.
- IDLE: start=1 -> WAIT_REQ. Otherwise stay in IDLE.
- WAIT_REQ: a_req_vz & b_req_vz & c_req_vz -> MAC with i=j=k=0. Otherwise stall indefinitely.
- The req inputs are sampled only in WAIT_REQ. After grant, the channels are held until release.
- MAC: a_re = b_re = 1 every cycle. k counts 0..N-1. At k=N-1 go to DRAIN.
- MAC addresses are maintained as running adders, with no multiplier:
  - a_radr = i*N + k, incremented by 1 per k.
  - b_radr = k*N + j, incremented by N per k.
- acc_en = a_re delayed by RD_LAT cycles.
- acc_clr = acc_en for the k=0 product only.
- DRAIN: lasts exactly RD_LAT cycles, with re = 0, so the last product accumulates. Then go to WRITE.
- WRITE: one cycle. c_we = 1, c_wadr = i*N + j; the datapath drives the accumulator register as data.
- WRITE exit:
  - If j < N-1: j++ and go to MAC.
  - Else if i < N-1: j=0, i++ and go to MAC.
  - Else go to RELEASE.
- RELEASE: one cycle. a_rls_lz = b_rls_lz = c_rls_lz = 1 and done = 1. Then go to IDLE.
- start while busy is ignored: no queuing, no effect.
- Per-element period is N + RD_LAT + 1 cycles.
- Full run latency, with req already high: 2 + N*N*(N+RD_LAT+1) + 1 cycles from start sample to done.
- Addresses never exceed N*N-1. The counters wrap to 0 only via the WRITE/IDLE transitions.
- When re/we are 0, address outputs hold their last value; they are don't-care for the RAM.
- The i, j, k counters are clog2(N) bits wide. Address arithmetic is AW bits wide with no overflow, since N*N <= 2^AW.

Test Plan:
- Reset values: assert arst_n low mid-cycle -> all outputs 0 immediately (asynchronous); after release, busy=0 and state IDLE.
- Element (0,0) addressing (N=10, RD_LAT=1): start at cycle 0, all req high -> busy from cycle 1.
  - Cycles 2-11: a_radr 0..9 and b_radr 0,10,...,90.
  - acc_en cycles 3-12, with acc_clr at cycle 3.
  - c_we at cycle 13 with c_wadr 0.
- Element sequencing: the second element reads a_radr 0..9 and b_radr 1,11,...,91, and writes c_wadr 1 at cycle 25.
  - The element-10 write is c_wadr 10, with a_radr 10..19 for its reads.
  - The last write is c_wadr 99 at cycle 1201.
  - rls_lz (all three) and done are high at cycle 1202 only; busy=0 at cycle 1203.
- Handshake stall: hold c_req_vz=0 for 5 cycles after start -> remain in WAIT_REQ with a_re=0. The first a_re comes 1 cycle after c_req_vz rises.
- start pulse at cycle 500 while busy -> no effect; done occurs once at cycle 1202.
- Reset at cycle 300 -> outputs 0 and no rls/done. A subsequent start runs a complete, correct pass. The bench also checks golden C values from a model driving RAMs filled with random 16-bit data.

Source files
------------

// File: rtl/matmult_run_ctrl_if.sv
// rtl/matmult_run_ctrl_if.sv - run-control bus between system, channel arbiter, RAMs and MAC datapath
interface matmult_run_ctrl_if #(
    parameter int AW = 7
);
    logic          start;
    logic          busy;
    logic          done;
    logic          a_req_vz;
    logic          b_req_vz;
    logic          c_req_vz;
    logic          a_rls_lz;
    logic          b_rls_lz;
    logic          c_rls_lz;
    logic          a_re;
    logic [AW-1:0] a_radr;
    logic          b_re;
    logic [AW-1:0] b_radr;
    logic          c_we;
    logic [AW-1:0] c_wadr;
    logic          acc_en;
    logic          acc_clr;

    // System / channel / datapath side
    modport master (
        output start, a_req_vz, b_req_vz, c_req_vz,
        input  busy, done, a_rls_lz, b_rls_lz, c_rls_lz,
        input  a_re, a_radr, b_re, b_radr, c_we, c_wadr, acc_en, acc_clr
    );

    // Controller side
    modport slave (
        input  start, a_req_vz, b_req_vz, c_req_vz,
        output busy, done, a_rls_lz, b_rls_lz, c_rls_lz,
        output a_re, a_radr, b_re, b_radr, c_we, c_wadr, acc_en, acc_clr
    );
endinterface

// File: rtl/matmult_run_ctrl.sv
// rtl/matmult_run_ctrl.sv - NxN matrix multiply sequencer: channel handshake, RAM addressing, MAC control
module matmult_run_ctrl #(
    parameter int N      = 10,
    parameter int AW     = 7,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               arst_n,
    matmult_run_ctrl_if.slave  bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [KW-1:0] K_LAST     = KW'(N - 1);
    localparam logic [KW-1:0] K_ONE      = KW'(1);
    localparam logic [AW-1:0] A_STEP     = AW'(N);
    localparam logic [AW-1:0] A_ONE      = AW'(1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT - 1);
    localparam logic [DW-1:0] D_ONE      = DW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t            r_state;
    logic [KW-1:0]     r_i;
    logic [KW-1:0]     r_j;
    logic [KW-1:0]     r_k;
    logic [DW-1:0]     r_drain;
    logic [AW-1:0]     r_row_base;   // i*N, kept as a running sum
    logic [AW-1:0]     r_a_adr;
    logic [AW-1:0]     r_b_adr;
    logic [AW-1:0]     r_c_adr;
    logic              r_re;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_rls;
    logic [RD_LAT-1:0] r_en_pipe;
    logic [RD_LAT-1:0] r_clr_pipe;
    logic              w_first_rd;

    // The read issued at k=0 starts a fresh accumulation
    assign w_first_rd = r_re && (r_k == '0);

    // Sequencer: state, counters and all registered strobes/addresses
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_drain    <= '0;
            r_row_base <= '0;
            r_a_adr    <= '0;
            r_b_adr    <= '0;
            r_c_adr    <= '0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rls      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_WAIT_REQ;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT_REQ: begin
                    if (bus.a_req_vz && bus.b_req_vz && bus.c_req_vz) begin
                        r_state    <= S_MAC;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_k        <= '0;
                        r_row_base <= '0;
                        r_a_adr    <= '0;
                        r_b_adr    <= '0;
                        r_re       <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (r_k == K_LAST) begin
                        r_state <= S_DRAIN;
                        r_re    <= 1'b0;
                        r_drain <= '0;
                    end else begin
                        r_k     <= r_k + K_ONE;
                        r_a_adr <= r_a_adr + A_ONE;
                        r_b_adr <= r_b_adr + A_STEP;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= S_WRITE;
                        r_we    <= 1'b1;
                        r_c_adr <= r_row_base + AW'(r_j);
                    end else begin
                        r_drain <= r_drain + D_ONE;
                    end
                end
                S_WRITE: begin
                    r_we <= 1'b0;
                    r_k  <= '0;
                    if (r_j != K_LAST) begin
                        r_j     <= r_j + K_ONE;
                        r_a_adr <= r_row_base;
                        r_b_adr <= AW'(r_j) + A_ONE;
                        r_re    <= 1'b1;
                        r_state <= S_MAC;
                    end else if (r_i != K_LAST) begin
                        r_j        <= '0;
                        r_i        <= r_i + K_ONE;
                        r_row_base <= r_row_base + A_STEP;
                        r_a_adr    <= r_row_base + A_STEP;
                        r_b_adr    <= '0;
                        r_re       <= 1'b1;
                        r_state    <= S_MAC;
                    end else begin
                        r_state <= S_RELEASE;
                        r_rls   <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                    r_rls   <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_k     <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Product-valid strobes trail the read enable by the RAM read latency
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_en_pipe  <= '0;
            r_clr_pipe <= '0;
        end else begin
            r_en_pipe[0]  <= r_re;
            r_clr_pipe[0] <= w_first_rd;
            for (int s = 1; s < RD_LAT; s++) begin
                r_en_pipe[s]  <= r_en_pipe[s-1];
                r_clr_pipe[s] <= r_clr_pipe[s-1];
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.a_rls_lz = r_rls;
    assign bus.b_rls_lz = r_rls;
    assign bus.c_rls_lz = r_rls;
    assign bus.a_re     = r_re;
    assign bus.b_re     = r_re;
    assign bus.a_radr   = r_a_adr;
    assign bus.b_radr   = r_b_adr;
    assign bus.c_we     = r_we;
    assign bus.c_wadr   = r_c_adr;
    assign bus.acc_en   = r_en_pipe[RD_LAT-1];
    assign bus.acc_clr  = r_clr_pipe[RD_LAT-1];
endmodule

// File: tb/tb_matmult_run_ctrl.sv
// tb/tb_matmult_run_ctrl.sv - directed bench for matmult_run_ctrl with RAM/MAC model and golden C
module tb_matmult_run_ctrl;
    localparam int N  = 10;
    localparam int AW = 7;
    localparam int NN = N * N;

    logic clk;
    logic arst_n;
    int   n_pass;
    int   n_total;
    logic clr_c;

    logic [15:0] mem_a [0:NN-1];
    logic [15:0] mem_b [0:NN-1];
    logic [39:0] mem_c [0:NN-1];
    logic [15:0] q_a;
    logic [15:0] q_b;
    logic [39:0] acc;

    matmult_run_ctrl_if #(.AW(AW)) bus ();

    matmult_run_ctrl #(.N(N), .AW(AW), .RD_LAT(1)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    wire [9:0]  w_ctrl = {bus.busy, bus.done, bus.a_rls_lz, bus.b_rls_lz, bus.c_rls_lz,
                          bus.a_re, bus.b_re, bus.c_we, bus.acc_en, bus.acc_clr};
    wire [30:0] w_all  = {w_ctrl, bus.a_radr, bus.b_radr, bus.c_wadr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync RAMs (latency 1) and the MAC datapath driven by the controller
    always @(posedge clk) begin
        if (bus.a_re === 1'b1) q_a <= mem_a[bus.a_radr];
        if (bus.b_re === 1'b1) q_b <= mem_b[bus.b_radr];
        if (bus.acc_en === 1'b1)
            acc <= (bus.acc_clr === 1'b1) ? 40'(q_a) * 40'(q_b) : acc + 40'(q_a) * 40'(q_b);
        if (clr_c) begin
            for (int x = 0; x < NN; x++) mem_c[x] <= '1;
        end else if (bus.c_we === 1'b1) begin
            mem_c[bus.c_wadr] <= acc;
        end
    end

    task automatic fill_rams();
        for (int x = 0; x < NN; x++) begin
            mem_a[x] = 16'($urandom);
            mem_b[x] = 16'($urandom);
        end
    endtask

    // One full run from start sample (cycle 0), checking every cycle against the schedule
    task automatic run_timeline(input int stall, input int poke_at, input string tag);
        int cc, d, e, p, ii, jj, dones;
        logic in_mac, x_busy, x_rel, x_re, x_en, x_clr, x_we;
        logic [9:0]  x_ctrl;
        logic [39:0] gold;
        bus.a_req_vz = 1'b1;
        bus.b_req_vz = 1'b1;
        bus.c_req_vz = (stall == 0);
        bus.start    = 1'b1;
        clr_c        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        clr_c     = 1'b0;
        dones     = 0;
        for (int c = 1; c <= 1203 + stall; c++) begin
            if (c == 1 + stall) bus.c_req_vz = 1'b1;
            bus.start = (c == poke_at);
            cc     = c - stall;
            in_mac = (cc >= 2) && (cc <= 1201);
            d = in_mac ? cc - 2 : 0;
            e = d / 12;
            p = d % 12;
            ii = e / N;
            jj = e % N;
            x_busy = (c >= 1) && (cc <= 1202);
            x_rel  = (cc == 1202);
            x_re   = in_mac && (p < 10);
            x_en   = in_mac && (p >= 1) && (p <= 10);
            x_clr  = in_mac && (p == 1);
            x_we   = in_mac && (p == 11);
            x_ctrl = {x_busy, x_rel, x_rel, x_rel, x_rel, x_re, x_re, x_we, x_en, x_clr};
            if (bus.done === 1'b1) dones++;
            n_total++;
            if (w_ctrl !== x_ctrl)
                $display("FAIL %s ctrl c=%0d got %b want %b", tag, c, w_ctrl, x_ctrl);
            else n_pass++;
            if (x_re) begin
                n_total++;
                if (bus.a_radr !== AW'(ii * N + p) || bus.b_radr !== AW'(p * N + jj))
                    $display("FAIL %s radr c=%0d got a=%0d b=%0d want a=%0d b=%0d",
                             tag, c, bus.a_radr, bus.b_radr, ii * N + p, p * N + jj);
                else n_pass++;
            end
            if (x_we) begin
                n_total++;
                if (bus.c_wadr !== AW'(e))
                    $display("FAIL %s wadr c=%0d got %0d want %0d", tag, c, bus.c_wadr, e);
                else n_pass++;
            end
            if (stall > 0 && (c == 1 + stall || c == 2 + stall)) begin
                n_total++;
                if (bus.a_re !== (c == 2 + stall))
                    $display("FAIL %s stall_are c=%0d got %b want %b", tag, c, bus.a_re, (c == 2 + stall));
                else n_pass++;
            end
            if (cc == 122) begin
                n_total++;
                if (bus.a_radr !== 7'd10)
                    $display("FAIL %s elem10_radr got %0d want 10", tag, bus.a_radr);
                else n_pass++;
            end
            if (cc == 1203) begin
                n_total++;
                if (bus.busy !== 1'b0)
                    $display("FAIL %s busy_after_done got %b want 0", tag, bus.busy);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        n_total++;
        if (dones != 1) $display("FAIL %s done_count got %0d want 1", tag, dones);
        else n_pass++;
        for (int r = 0; r < N; r++) begin
            for (int q = 0; q < N; q++) begin
                gold = '0;
                for (int k = 0; k < N; k++)
                    gold = gold + 40'(mem_a[r * N + k]) * 40'(mem_b[k * N + q]);
                n_total++;
                if (mem_c[r * N + q] !== gold)
                    $display("FAIL %s golden C[%0d][%0d] got %0h want %0h",
                             tag, r, q, mem_c[r * N + q], gold);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a_req_vz = 1'b0;
        bus.b_req_vz = 1'b0;
        bus.c_req_vz = 1'b0;
        clr_c  = 1'b0;
        arst_n = 1'b1;
        #2 arst_n = 1'b0;
        #1;
        n_total++;
        if (w_all !== 31'd0) $display("FAIL reset_async got %h want 0", w_all);
        else n_pass++;
        @(posedge clk); #3 arst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (w_all !== 31'd0) $display("FAIL reset_idle got %h want 0", w_all);
        else n_pass++;
    endtask

    task automatic test_full_run();
        fill_rams();
        run_timeline(0, 500, "full");
    endtask

    task automatic test_stall();
        fill_rams();
        run_timeline(5, 0, "stall");
    endtask

    task automatic test_back_to_back();
        fill_rams();
        run_timeline(0, 0, "b2b_1");
        fill_rams();
        run_timeline(0, 0, "b2b_2");
    endtask

    task automatic test_reset_mid_run();
        int rls_seen;
        fill_rams();
        bus.a_req_vz = 1'b1;
        bus.b_req_vz = 1'b1;
        bus.c_req_vz = 1'b1;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        rls_seen  = 0;
        for (int c = 1; c < 300; c++) begin
            if (bus.done === 1'b1 || bus.a_rls_lz === 1'b1 || bus.c_rls_lz === 1'b1) rls_seen++;
            @(posedge clk); #1;
        end
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL midrst busy_before got %b want 1", bus.busy);
        else n_pass++;
        #2 arst_n = 1'b0;
        #1;
        n_total++;
        if (w_all !== 31'd0) $display("FAIL midrst async_zero got %h want 0", w_all);
        else n_pass++;
        @(posedge clk); #3 arst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.a_rls_lz === 1'b1 || bus.c_we === 1'b1) rls_seen++;
        end
        n_total++;
        if (rls_seen != 0) $display("FAIL midrst no_release got %0d want 0", rls_seen);
        else n_pass++;
        n_total++;
        if (w_ctrl !== 10'd0) $display("FAIL midrst idle_after got %b want 0", w_ctrl);
        else n_pass++;
        fill_rams();
        run_timeline(0, 0, "after_rst");
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_full_run();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
